// File: rtl/symbol_pkg.sv
`timescale 1ns/1ps
// Shared definitions for the 4-slot serial symbol line (send and receive sides).
package symbol_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOW,
        HIGH,
        GAP,
        ERR
    } rx_state_t;

    // Every symbol is SYM_SLOTS slots long; the low-run length encodes the bit.
    localparam logic [2:0] SYM_SLOTS = 3'd4;
    localparam logic [2:0] LOW_ZERO  = 3'd1;
    localparam logic [2:0] LOW_ONE   = 3'd3;

    // Consecutive high slots needed to leave the error state.
    localparam logic [2:0] ERR_CLEAR = 3'd4;

endpackage

// File: rtl/symbol_slicer.sv
`timescale 1ns/1ps
// Symbol slicer: counts the low and high runs of one symbol and reports a
// decoded bit, a malformed symbol, or the LOW->HIGH hand-over to the top FSM.
module symbol_slicer
    import symbol_pkg::*;
(
    input  logic      clk,
    input  logic      rst_n,
    input  logic      clr_i,
    input  rx_state_t state_i,
    input  logic      line_i,
    output logic      bit_o,
    output logic      bit_strobe_o,
    output logic      to_high_o,
    output logic      sym_err_o
);

    logic [2:0] low_cnt_q, low_cnt_d;
    logic [2:0] hi_cnt_q,  hi_cnt_d;
    logic [2:0] low_next;
    logic [2:0] hi_next;

    // Run counting; completion is judged including the slot being consumed now,
    // so a '1' symbol completes on its single high slot straight out of LOW.
    always_comb begin
        low_cnt_d    = low_cnt_q;
        hi_cnt_d     = hi_cnt_q;
        bit_strobe_o = 1'b0;
        to_high_o    = 1'b0;
        sym_err_o    = 1'b0;
        bit_o        = (low_cnt_q == LOW_ONE);
        low_next     = low_cnt_q + 3'd1;
        hi_next      = (state_i == HIGH) ? hi_cnt_q + 3'd1 : 3'd1;
        if (clr_i) begin
            low_cnt_d = '0;
            hi_cnt_d  = '0;
        end else begin
            case (state_i)
                IDLE, GAP: begin
                    if (!line_i) begin
                        low_cnt_d = 3'd1;
                        hi_cnt_d  = '0;
                    end
                end
                LOW: begin
                    if (!line_i) begin
                        // A full symbol of low slots is a line break.
                        if (low_next == SYM_SLOTS) sym_err_o = 1'b1;
                        else                       low_cnt_d = low_next;
                    end else if (low_cnt_q != LOW_ZERO && low_cnt_q != LOW_ONE) begin
                        sym_err_o = 1'b1;
                    end else if (low_cnt_q + hi_next == SYM_SLOTS) begin
                        bit_strobe_o = 1'b1;
                    end else begin
                        to_high_o = 1'b1;
                        hi_cnt_d  = hi_next;
                    end
                end
                HIGH: begin
                    // Line dropping before the symbol is complete is a short symbol.
                    if (!line_i)                                 sym_err_o    = 1'b1;
                    else if (low_cnt_q + hi_next == SYM_SLOTS)   bit_strobe_o = 1'b1;
                    else                                         hi_cnt_d     = hi_next;
                end
                default: ;
            endcase
        end
    end

    // Run counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            low_cnt_q <= '0;
            hi_cnt_q  <= '0;
        end else begin
            low_cnt_q <= low_cnt_d;
            hi_cnt_q  <= hi_cnt_d;
        end
    end

endmodule

// File: rtl/symbol_receive.sv
`timescale 1ns/1ps
// Receiver for the 4-slot serial symbol line: decodes symbols into bits,
// packs them MSB-first into words and flags malformed symbols or timeouts.
module symbol_receive
    import symbol_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int IDLE_TO = 8
) (
    input  logic              clk,
    input  logic              Reset,
    input  logic              Enable,
    input  logic              Data_In,
    output logic [DATA_W-1:0] Data_Out,
    output logic              Data_Valid,
    output logic              Frame_Err,
    output logic              Busy
);

    localparam int BW = $clog2(DATA_W + 1);
    localparam int GW = $clog2(IDLE_TO + 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'(IDLE_TO - 1);

    rx_state_t         state_q, state_d;
    logic              line_q;
    logic [DATA_W-1:0] sreg_q, sreg_d, sreg_shift;
    logic [BW-1:0]     bit_cnt_q, bit_cnt_d;
    logic [GW-1:0]     gap_cnt_q, gap_cnt_d;
    logic [2:0]        err_cnt_q, err_cnt_d;
    logic [DATA_W-1:0] dout_q, dout_d;
    logic              valid_q, valid_d;
    logic              ferr_q, ferr_d;
    logic              go_err;

    logic sym_bit, bit_strobe, to_high, sym_err;

    symbol_slicer u_slicer (
        .clk          (clk),
        .rst_n        (Reset),
        .clr_i        (!Enable),
        .state_i      (state_q),
        .line_i       (line_q),
        .bit_o        (sym_bit),
        .bit_strobe_o (bit_strobe),
        .to_high_o    (to_high),
        .sym_err_o    (sym_err)
    );

    // Word assembly, gap timeout and error recovery; strobes default low.
    always_comb begin
        state_d    = state_q;
        sreg_d     = sreg_q;
        bit_cnt_d  = bit_cnt_q;
        gap_cnt_d  = gap_cnt_q;
        err_cnt_d  = err_cnt_q;
        dout_d     = dout_q;
        valid_d    = 1'b0;
        ferr_d     = 1'b0;
        go_err     = 1'b0;
        sreg_shift = {sreg_q[DATA_W-2:0], sym_bit};
        if (!Enable) begin
            state_d   = IDLE;
            sreg_d    = '0;
            bit_cnt_d = '0;
            gap_cnt_d = '0;
            err_cnt_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (!line_q) state_d = LOW;
                end
                LOW, HIGH: begin
                    if (sym_err) begin
                        go_err = 1'b1;
                    end else if (bit_strobe) begin
                        state_d   = GAP;
                        gap_cnt_d = '0;
                        if (bit_cnt_q == LAST_BIT) begin
                            dout_d    = sreg_shift;
                            valid_d   = 1'b1;
                            sreg_d    = '0;
                            bit_cnt_d = '0;
                        end else begin
                            sreg_d    = sreg_shift;
                            bit_cnt_d = bit_cnt_q + BW'(1);
                        end
                    end else if (to_high) begin
                        state_d = HIGH;
                    end
                end
                GAP: begin
                    if (!line_q) begin
                        state_d = LOW;
                    end else if (gap_cnt_q == GAP_LAST) begin
                        // Timeout only matters if a partial word would be lost.
                        if (bit_cnt_q != '0) go_err  = 1'b1;
                        else                 state_d = IDLE;
                    end else begin
                        gap_cnt_d = gap_cnt_q + GW'(1);
                    end
                end
                ERR: begin
                    if (!line_q)                              err_cnt_d = '0;
                    else if (err_cnt_q + 3'd1 == ERR_CLEAR)   state_d   = IDLE;
                    else                                      err_cnt_d = err_cnt_q + 3'd1;
                end
                default: state_d = IDLE;
            endcase
            if (go_err) begin
                state_d   = ERR;
                ferr_d    = 1'b1;
                sreg_d    = '0;
                bit_cnt_d = '0;
                err_cnt_d = '0;
            end
        end
    end

    // State, line sampler and output registers.
    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            state_q   <= IDLE;
            line_q    <= 1'b1;
            sreg_q    <= '0;
            bit_cnt_q <= '0;
            gap_cnt_q <= '0;
            err_cnt_q <= '0;
            dout_q    <= '0;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            line_q    <= Data_In;
            sreg_q    <= sreg_d;
            bit_cnt_q <= bit_cnt_d;
            gap_cnt_q <= gap_cnt_d;
            err_cnt_q <= err_cnt_d;
            dout_q    <= dout_d;
            valid_q   <= valid_d;
            ferr_q    <= ferr_d;
        end
    end

    assign Data_Out   = dout_q;
    assign Data_Valid = valid_q;
    assign Frame_Err  = ferr_q;
    assign Busy       = (bit_cnt_q != '0) || (state_q == LOW) || (state_q == HIGH);

endmodule

// File: tb/tb_symbol_receive.sv
`timescale 1ns/1ps
// Bench for symbol_receive: the stimulus side knows what it sends, so it
// schedules the expected strobes, Busy windows and Data_Out per cycle; a
// monitor samples the DUT each cycle and compares with a fixed lag.
module tb_symbol_receive;

    localparam int DW   = 8;
    localparam int ITO  = 8;
    localparam int MAXC = 40000;
    localparam int LAG  = 160;

    logic          clk = 1'b0;
    logic          Reset, Enable, Data_In;
    logic [DW-1:0] Data_Out;
    logic          Data_Valid, Frame_Err, Busy;

    symbol_receive #(.DATA_W(DW), .IDLE_TO(ITO)) dut (
        .clk        (clk),
        .Reset      (Reset),
        .Enable     (Enable),
        .Data_In    (Data_In),
        .Data_Out   (Data_Out),
        .Data_Valid (Data_Valid),
        .Frame_Err  (Frame_Err),
        .Busy       (Busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // expected per cycle (written by stimulus) and sampled per cycle (monitor)
    bit            exp_v   [MAXC];
    bit            exp_e   [MAXC];
    bit            exp_b   [MAXC];
    bit            exp_clr [MAXC];
    logic [DW-1:0] exp_w   [MAXC];
    logic          act_v   [MAXC];
    logic          act_e   [MAXC];
    logic          act_b   [MAXC];
    logic [DW-1:0] act_d   [MAXC];
    logic [DW-1:0] model_dout = '0;

    int checks = 0, errors = 0, nvalid = 0, nerr = 0;
    int gap_tab [DW];
    int ev, v0, e0, c, start, last, r, nb;
    logic [DW-1:0] w;

    task automatic check(input string name, input int at, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0h, want %0h", name, at, got, want);
        end
    endtask

    task automatic monitor();
        int k, s;
        forever begin
            @(negedge clk);
            s = cyc;
            if (s < MAXC) begin
                act_v[s] = Data_Valid;
                act_e[s] = Frame_Err;
                act_b[s] = Busy;
                act_d[s] = Data_Out;
                if (Data_Valid === 1'b1) nvalid++;
                if (Frame_Err === 1'b1) nerr++;
            end
            if (s >= LAG && s - LAG < MAXC) begin
                k = s - LAG;
                if (exp_clr[k]) model_dout = '0;
                if (exp_v[k])   model_dout = exp_w[k];
                check("valid", k, 32'(act_v[k]), 32'(exp_v[k]));
                check("frame_err", k, 32'(act_e[k]), 32'(exp_e[k]));
                check("busy", k, 32'(act_b[k]), 32'(exp_b[k]));
                check("data_out", k, 32'(act_d[k]), 32'(model_dout));
            end
        end
    endtask

    task automatic slot(input logic v);
        Data_In = v;
        @(posedge clk);
        #1;
    endtask

    task automatic highs(input int n);
        for (int i = 0; i < n; i++) slot(1'b1);
    endtask

    task automatic wait_to(input int t);
        while (cyc < t) slot(1'b1);
    endtask

    task automatic mark_busy(input int a, input int b);
        for (int i = a; i < b; i++) exp_b[i] = 1'b1;
    endtask

    // '0' = 0,1,1,1 ; '1' = 0,0,0,1 ; returns the cycle of the final slot
    task automatic send_sym(input logic b, output int lst);
        slot(1'b0);
        slot(b ? 1'b0 : 1'b1);
        slot(b ? 1'b0 : 1'b1);
        lst = cyc;
        slot(1'b1);
    endtask

    // term 0: full word; 1: nbits then idle timeout; 2: nbits then malformed symbol mt
    task automatic send_word(input logic [DW-1:0] wd, input int nbits, input int term,
                             input int mt, output int evc);
        int st, ls, es;
        st = cyc;
        ls = cyc;
        es = cyc;
        for (int i = 0; i < nbits; i++) begin
            send_sym(wd[DW-1-i], ls);
            if (i < nbits - 1) highs(gap_tab[i]);
        end
        if (term == 0) begin
            evc = ls + 2;
            exp_v[evc] = 1'b1;
            exp_w[evc] = wd;
        end else begin
            if (term == 1) begin
                highs(ITO - 1);
                es = cyc;
                slot(1'b1);
            end else if (mt == 0) begin        // two low slots
                slot(1'b0); slot(1'b0); es = cyc; slot(1'b1);
            end else if (mt == 1) begin        // four low slots: break
                slot(1'b0); slot(1'b0); slot(1'b0); es = cyc; slot(1'b0);
            end else begin                     // short symbol 0,1,0
                slot(1'b0); slot(1'b1); es = cyc; slot(1'b0);
            end
            evc = es + 2;
            exp_e[evc] = 1'b1;
        end
        mark_busy(st + 2, evc);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        Reset = 1'b0;
        Enable = 1'b1;
        Data_In = 1'b1;
        for (int i = 0; i < DW; i++) gap_tab[i] = 0;
        fork
            monitor();
        join_none
        repeat (3) @(posedge clk);
        #1;
        check("reset data_out", cyc, 32'(Data_Out), 32'h0);
        check("reset valid", cyc, 32'(Data_Valid), 32'h0);
        check("reset frame_err", cyc, 32'(Frame_Err), 32'h0);
        check("reset busy", cyc, 32'(Busy), 32'h0);
        Reset = 1'b1;
        highs(3);

        // 0xA5 back-to-back
        v0 = nvalid; e0 = nerr;
        send_word(8'hA5, DW, 0, 0, ev);
        wait_to(ev);
        check("A5 valid", cyc, 32'(Data_Valid), 32'h1);
        check("A5 data", cyc, 32'(Data_Out), 32'hA5);
        check("A5 busy after", cyc, 32'(Busy), 32'h0);
        highs(4);
        check("A5 pulse count", cyc, 32'(nvalid - v0), 32'h1);
        check("A5 no err", cyc, 32'(nerr - e0), 32'h0);

        // 0x3C with 5 idle slots after bit 3
        gap_tab[3] = 5;
        e0 = nerr;
        send_word(8'h3C, DW, 0, 0, ev);
        gap_tab[3] = 0;
        wait_to(ev);
        check("3C valid", cyc, 32'(Data_Valid), 32'h1);
        check("3C data", cyc, 32'(Data_Out), 32'h3C);
        highs(4);
        check("3C no err", cyc, 32'(nerr - e0), 32'h0);

        // 4 bits then timeout, then 0x81
        v0 = nvalid;
        send_word(8'hF0, 4, 1, 0, ev);
        wait_to(ev);
        check("timeout err", cyc, 32'(Frame_Err), 32'h1);
        check("timeout busy", cyc, 32'(Busy), 32'h0);
        check("timeout holds data", cyc, 32'(Data_Out), 32'h3C);
        highs(4);
        check("timeout no valid", cyc, 32'(nvalid - v0), 32'h0);
        send_word(8'h81, DW, 0, 0, ev);
        wait_to(ev);
        check("81 data", cyc, 32'(Data_Out), 32'h81);
        check("81 valid", cyc, 32'(Data_Valid), 32'h1);
        highs(2);

        // malformed: two low slots, then a break; recover and decode 0x5A
        e0 = nerr;
        send_word(8'h00, 0, 2, 0, ev);
        wait_to(ev);
        check("2-low err", cyc, 32'(Frame_Err), 32'h1);
        highs(4);
        send_word(8'h00, 0, 2, 1, ev);
        wait_to(ev);
        check("break err", cyc, 32'(Frame_Err), 32'h1);
        highs(4);
        check("malformed err count", cyc, 32'(nerr - e0), 32'h2);
        send_word(8'h5A, DW, 0, 0, ev);
        wait_to(ev);
        check("5A data", cyc, 32'(Data_Out), 32'h5A);
        highs(2);

        // Enable drop after 5 bits of 0xFF
        v0 = nvalid; e0 = nerr;
        start = cyc;
        for (int i = 0; i < 5; i++) send_sym(1'b1, last);
        Enable = 1'b0;
        c = cyc;
        mark_busy(start + 2, c + 1);
        slot(1'b1);
        highs(2);
        Enable = 1'b1;
        highs(3);
        check("enable drop no strobes", cyc, 32'((nvalid - v0) + (nerr - e0)), 32'h0);
        check("enable drop busy", cyc, 32'(Busy), 32'h0);
        check("enable drop holds data", cyc, 32'(Data_Out), 32'h5A);
        send_word(8'h0F, DW, 0, 0, ev);
        wait_to(ev);
        check("0F after enable", cyc, 32'(Data_Out), 32'h0F);
        highs(2);

        // async Reset after 5 bits of 0xFF
        v0 = nvalid; e0 = nerr;
        start = cyc;
        for (int i = 0; i < 5; i++) send_sym(1'b1, last);
        Reset = 1'b0;
        c = cyc;
        exp_clr[c] = 1'b1;
        mark_busy(start + 2, c);
        #1;
        check("reset mid busy", cyc, 32'(Busy), 32'h0);
        check("reset mid data", cyc, 32'(Data_Out), 32'h0);
        highs(3);
        Reset = 1'b1;
        highs(2);
        check("reset mid no strobes", cyc, 32'((nvalid - v0) + (nerr - e0)), 32'h0);
        send_word(8'h0F, DW, 0, 0, ev);
        wait_to(ev);
        check("0F after reset", cyc, 32'(Data_Out), 32'h0F);
        highs(2);

        // randomized traffic
        for (int n = 0; n < 120; n++) begin
            w = DW'($urandom);
            r = int'($urandom_range(19, 0));
            for (int i = 0; i < DW; i++)
                gap_tab[i] = ($urandom_range(3, 0) == 0) ? int'($urandom_range(ITO - 1, 0)) : 0;
            if (r < 14) begin
                send_word(w, DW, 0, 0, ev);
                highs(int'($urandom_range(12, 0)));
            end else if (r < 17) begin
                nb = int'($urandom_range(DW - 1, 1));
                send_word(w, nb, 1, 0, ev);
                highs(4 + int'($urandom_range(6, 0)));
            end else begin
                nb = int'($urandom_range(DW - 1, 0));
                send_word(w, nb, 2, int'($urandom_range(2, 0)), ev);
                highs(4 + int'($urandom_range(6, 0)));
            end
        end
        highs(LAG + 10);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
